mult_share_arbiter: RTL and testbench

Round-robin arbiter that time-shares one big-number block multiplier (n×m, streamed as 32-bit blocks, product streamed back as twice as many blocks) between two requesters, e.g. two modular-exponentiation engines. It owns the multiplier's input port for one whole operand load, then routes the product stream and final pulse back to the requester that loaded it. Only then does it grant the next requester.

---
 rtl/mult_share_arbiter.sv | 148 ++++++++++++++
 tb/tb_mult_share_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter: round-robin sharing of one streamed block multiplier between two requesters.
// The owner keeps the multiplier from the first operand block until its product's final pulse.
module mult_share_arbiter #(
  parameter int REGISTER_SIZE = 32,
  parameter int BITS_IN_NUM   = 4096
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic [1:0]                 req_in,
  input  logic [2*REGISTER_SIZE-1:0] n_in,
  input  logic [2*REGISTER_SIZE-1:0] m_in,
  input  logic [1:0]                 valid_in,
  output logic [1:0]                 grant_out,
  output logic [REGISTER_SIZE-1:0]   res_data_out,
  output logic [1:0]                 res_valid_out,
  output logic [1:0]                 res_final_out,
  output logic                       busy_out,
  output logic [REGISTER_SIZE-1:0]   mult_n_out,
  output logic [REGISTER_SIZE-1:0]   mult_m_out,
  output logic                       mult_valid_out,
  input  logic                       mult_ready_in,
  input  logic [REGISTER_SIZE-1:0]   mult_data_in,
  input  logic                       mult_valid_in,
  input  logic                       mult_final_in
);

  localparam int NUM_BLOCKS = BITS_IN_NUM / REGISTER_SIZE;
  localparam int CW         = $clog2(NUM_BLOCKS + 1);
  localparam logic [CW-1:0] LAST_BLK = CW'(NUM_BLOCKS - 1);
  localparam logic [CW-1:0] FULL_BLK = CW'(NUM_BLOCKS);
  localparam logic [CW-1:0] ONE_BLK  = CW'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FEED  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            owner_q, owner_d;
  logic            rr_last_q, rr_last_d;
  logic [CW-1:0]   blk_cnt_q, blk_cnt_d;
  logic [1:0]      grant_q, grant_d;
  logic            busy_q, busy_d;

  logic [REGISTER_SIZE-1:0] owner_n_s;
  logic [REGISTER_SIZE-1:0] owner_m_s;
  logic                     owner_valid_s;

  assign owner_n_s     = owner_q ? n_in[2*REGISTER_SIZE-1:REGISTER_SIZE] : n_in[REGISTER_SIZE-1:0];
  assign owner_m_s     = owner_q ? m_in[2*REGISTER_SIZE-1:REGISTER_SIZE] : m_in[REGISTER_SIZE-1:0];
  // A full load is never extended, even if the owner keeps valid high.
  assign owner_valid_s = valid_in[owner_q] && (blk_cnt_q < FULL_BLK);

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    rr_last_d = rr_last_q;
    blk_cnt_d = blk_cnt_q;
    grant_d   = grant_q;
    busy_d    = busy_q;
    case (state_q)
      ST_IDLE: begin
        blk_cnt_d = '0;
        if (mult_ready_in && (req_in != 2'b00)) begin
          owner_d = (req_in == 2'b11) ? ~rr_last_q : req_in[1];
          state_d = ST_FEED;
          grant_d = owner_d ? 2'b10 : 2'b01;
          busy_d  = 1'b1;
        end else begin
          grant_d = 2'b00;
          busy_d  = 1'b0;
        end
      end
      ST_FEED: begin
        if (owner_valid_s) begin
          blk_cnt_d = blk_cnt_q + ONE_BLK;
          if (blk_cnt_q == LAST_BLK) begin
            state_d = ST_DRAIN;
            grant_d = 2'b00;
          end else begin
            state_d = ST_FEED;
          end
        end else begin
          blk_cnt_d = blk_cnt_q;
        end
      end
      ST_DRAIN: begin
        if (mult_final_in) begin
          state_d   = ST_IDLE;
          rr_last_d = owner_q;
          busy_d    = 1'b0;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = 2'b00;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and registered status outputs.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q   <= ST_IDLE;
      owner_q   <= 1'b0;
      rr_last_q <= 1'b1;
      blk_cnt_q <= '0;
      grant_q   <= 2'b00;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_last_q <= rr_last_d;
      blk_cnt_q <= blk_cnt_d;
      grant_q   <= grant_d;
      busy_q    <= busy_d;
    end
  end

  // Zero-latency routing of operands to the multiplier and products back to the owner.
  always_comb begin
    mult_n_out     = '0;
    mult_m_out     = '0;
    mult_valid_out = 1'b0;
    res_data_out   = '0;
    res_valid_out  = 2'b00;
    res_final_out  = 2'b00;
    if (state_q == ST_FEED) begin
      mult_n_out     = owner_n_s;
      mult_m_out     = owner_m_s;
      mult_valid_out = owner_valid_s;
    end else if (state_q == ST_DRAIN) begin
      res_data_out  = mult_data_in;
      res_valid_out = {mult_valid_in & owner_q, mult_valid_in & ~owner_q};
      res_final_out = {mult_final_in & owner_q, mult_final_in & ~owner_q};
    end else begin
      res_data_out = '0;
    end
  end

  assign grant_out = grant_q;
  assign busy_out  = busy_q;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Randomized bench for mult_share_arbiter: two requester models and a streaming multiplier model;
// products are checked against the big-number product of the operands each requester sent.
module tb_mult_share_arbiter;
  localparam int RS = 32;
  localparam int BN = 4096;
  localparam int NB = BN / RS;

  logic            clk_in = 1'b0;
  logic            rst_in;
  logic [1:0]      req_in, valid_in;
  logic [2*RS-1:0] n_in, m_in;
  logic [1:0]      grant_out, res_valid_out, res_final_out;
  logic [RS-1:0]   res_data_out, mult_n_out, mult_m_out, mult_data_in;
  logic            busy_out, mult_valid_out, mult_ready_in, mult_valid_in, mult_final_in;

  mult_share_arbiter #(.REGISTER_SIZE(RS), .BITS_IN_NUM(BN)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .req_in(req_in), .n_in(n_in), .m_in(m_in),
    .valid_in(valid_in), .grant_out(grant_out), .res_data_out(res_data_out),
    .res_valid_out(res_valid_out), .res_final_out(res_final_out), .busy_out(busy_out),
    .mult_n_out(mult_n_out), .mult_m_out(mult_m_out), .mult_valid_out(mult_valid_out),
    .mult_ready_in(mult_ready_in), .mult_data_in(mult_data_in),
    .mult_valid_in(mult_valid_in), .mult_final_in(mult_final_in)
  );

  always #5 clk_in = ~clk_in;

  int n_tests = 0;
  int n_fail  = 0;

  // requester models
  int            ops_left [2];
  bit            active [2];
  int            sent [2];
  int            grant_cyc [2];
  int            rescnt [2];
  logic [BN-1:0] opn [2];
  logic [BN-1:0] opm [2];
  logic [RS-1:0] resbuf [2][2*NB];
  int            owner_log [$];
  bit            last_owner;
  bit            alt_feed, alt_ph, noise1, mult_noise, force_unready, rst_req;
  int            mv_pulses, beef_seen;
  // multiplier model: 0 load, 1 compute, 2 stream, 3 final
  int              ms, mcnt, mwait;
  logic [BN-1:0]   ma, mb;
  logic [2*BN-1:0] mp;
  // what the DUT saw on the previous edge
  logic [1:0] prev_req;
  bit         prev_ready, prev_busy, prev_rst;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic new_operands(input int i, input bit unit);
    for (int k = 0; k < NB; k++) begin
      opn[i][k*RS +: RS] = unit ? RS'(k + 1) : $urandom;
      opm[i][k*RS +: RS] = unit ? ((k == 0) ? 32'd1 : 32'd0) : $urandom;
    end
  endtask

  task automatic finish_op(input int i);
    logic [2*BN-1:0] p;
    int bad;
    p   = {{BN{1'b0}}, opn[i]} * {{BN{1'b0}}, opm[i]};
    bad = 0;
    check_val("res_len", rescnt[i], 2*NB);
    for (int k = 0; k < rescnt[i]; k++)
      if (resbuf[i][k] !== p[k*RS +: RS]) bad++;
    check_val("res_blocks_bad", bad, 0);
    active[i]  = 1'b0;
    last_owner = i[0];
    if (ops_left[i] > 0) ops_left[i]--;
    if (ops_left[i] > 0) new_operands(i, 1'b0);
  endtask

  task automatic cycle();
    bit exp_own, drain0, drain1, d;
    logic [1:0] exp_g;
    int own;
    @(negedge clk_in);
    if (prev_rst) begin
      check_val("reset_ctl", {grant_out, busy_out, res_valid_out, res_final_out, mult_valid_out}, 0);
      check_val("reset_data", {res_data_out, mult_n_out}, 0);
      check_val("reset_m", mult_m_out, 0);
    end
    exp_own = (prev_req == 2'b11) ? ~last_owner : prev_req[1];
    if (!prev_busy && !prev_rst) begin
      exp_g = (prev_req != 2'b00 && prev_ready) ? (exp_own ? 2'b10 : 2'b01) : 2'b00;
      check_val("grant_idle", grant_out, exp_g);
    end
    check_val("grant_onehot", ($countones(grant_out) <= 1), 1);
    for (int i = 0; i < 2; i++)
      if (grant_out[i] && !active[i]) begin
        check_val("grant_when_busy", prev_busy, 0);
        check_val("owner_rr", i, exp_own);
        active[i] = 1'b1; sent[i] = 0; rescnt[i] = 0; grant_cyc[i] = 0; alt_ph = 1'b0;
        owner_log.push_back(i);
      end
    for (int i = 0; i < 2; i++)
      if (active[i]) begin
        check_val("grant_window", grant_out[i], sent[i] < NB);
        if (grant_out[i]) grant_cyc[i]++;
      end

    // drive requesters
    rst_in   = rst_req;
    req_in   = 2'b00;
    valid_in = 2'b00;
    n_in     = {$urandom, $urandom};
    m_in     = {$urandom, $urandom};
    for (int i = 0; i < 2; i++) begin
      if (!active[i] && ops_left[i] > 0) req_in[i] = 1'b1;
      if (active[i] && grant_out[i] && sent[i] < NB) begin
        if (!alt_feed || alt_ph) begin
          valid_in[i]        = 1'b1;
          n_in[i*RS +: RS]   = opn[i][sent[i]*RS +: RS];
          m_in[i*RS +: RS]   = opm[i][sent[i]*RS +: RS];
        end
        alt_ph = ~alt_ph;
      end else if (i == 1 && noise1 && !active[1] && ops_left[1] == 0) begin
        valid_in[1]     = 1'b1;
        n_in[RS +: RS]  = 32'hDEADBEEF;
        m_in[RS +: RS]  = 32'hDEADBEEF;
      end
    end
    // drive multiplier
    mult_ready_in = (ms == 0) && (mcnt == 0) && !force_unready;
    mult_valid_in = (ms == 2);
    mult_final_in = (ms == 3);
    mult_data_in  = (ms == 2) ? mp[mcnt*RS +: RS] : $urandom;
    if (mult_noise && ms == 0) begin
      mult_valid_in = ($urandom % 2) == 1;
      mult_final_in = ($urandom % 2) == 1;
    end
    #1;

    drain0 = active[0] && !grant_out[0];
    drain1 = active[1] && !grant_out[1];
    if (grant_out == 2'b00) begin
      check_val("mult_valid_idle", mult_valid_out, 0);
      check_val("mult_nm_idle", {mult_n_out, mult_m_out}, 0);
    end else begin
      own = grant_out[1] ? 1 : 0;
      check_val("mult_valid", mult_valid_out, valid_in[own]);
      check_val("mult_n", mult_n_out, n_in[own*RS +: RS]);
      check_val("mult_m", mult_m_out, m_in[own*RS +: RS]);
    end
    if (mult_valid_out && mult_n_out == 32'hDEADBEEF) beef_seen++;
    if (drain0 || drain1) begin
      d = drain1;
      check_val("res_valid", res_valid_out, {mult_valid_in & d, mult_valid_in & ~d});
      check_val("res_final", res_final_out, {mult_final_in & d, mult_final_in & ~d});
      check_val("res_data", res_data_out, mult_data_in);
    end else begin
      check_val("res_quiet", {res_valid_out, res_final_out}, 0);
      check_val("res_data_quiet", res_data_out, 0);
    end
    check_val("busy", busy_out, (grant_out != 2'b00) || drain0 || drain1);

    for (int i = 0; i < 2; i++)
      if (valid_in[i] && active[i] && grant_out[i]) sent[i]++;
    if (mult_valid_out) mv_pulses++;
    case (ms)
      0: if (mult_valid_out) begin
        ma[mcnt*RS +: RS] = mult_n_out;
        mb[mcnt*RS +: RS] = mult_m_out;
        mcnt++;
        if (mcnt == NB) begin
          mp = {{BN{1'b0}}, ma} * {{BN{1'b0}}, mb};
          ms = 1; mcnt = 0; mwait = 2;
        end
      end
      1: begin mwait--; if (mwait == 0) ms = 2; end
      2: begin mcnt++; if (mcnt == 2*NB) begin ms = 3; mcnt = 0; end end
      default: ms = 0;
    endcase
    for (int i = 0; i < 2; i++) begin
      if (active[i] && res_valid_out[i] && rescnt[i] < 2*NB) begin
        resbuf[i][rescnt[i]] = res_data_out;
        rescnt[i]++;
      end
      if (active[i] && res_final_out[i]) finish_op(i);
    end

    prev_req   = req_in;
    prev_ready = mult_ready_in;
    prev_busy  = busy_out;
    prev_rst   = rst_req;
    if (rst_req) begin
      for (int i = 0; i < 2; i++) begin active[i] = 1'b0; ops_left[i] = 0; end
      ms = 0; mcnt = 0; last_owner = 1'b1;
    end
  endtask

  task automatic run_ops(input int budget, input string tag);
    int c;
    c = 0;
    while ((ops_left[0] > 0 || ops_left[1] > 0 || active[0] || active[1]) && c < budget) begin
      cycle();
      c++;
    end
    check_val({"done_", tag}, (c < budget), 1);
    cycle();
  endtask

  initial begin
    int c;
    logic [2:0] ord;
    rst_in = 1'b1; req_in = 2'b00; valid_in = 2'b00; n_in = '0; m_in = '0;
    mult_ready_in = 1'b0; mult_valid_in = 1'b0; mult_final_in = 1'b0; mult_data_in = '0;
    for (int i = 0; i < 2; i++) begin ops_left[i] = 0; active[i] = 1'b0; sent[i] = 0; end
    alt_feed = 0; alt_ph = 0; noise1 = 0; mult_noise = 0; force_unready = 0;
    ms = 0; mcnt = 0; mwait = 0; last_owner = 1'b1;
    prev_req = 2'b00; prev_ready = 0; prev_busy = 1; prev_rst = 1;
    rst_req = 1'b1;
    cycle();
    cycle();
    rst_req = 1'b0;

    // contention: both requesters want three operations each
    new_operands(0, 1'b0); new_operands(1, 1'b0);
    ops_left[0] = 3; ops_left[1] = 3;
    owner_log.delete();
    run_ops(8000, "contend");
    check_val("contend_n_ops", owner_log.size(), 6);
    ord = 3'b111;
    if (owner_log.size() >= 3) ord = {owner_log[0][0], owner_log[1][0], owner_log[2][0]};
    check_val("contend_order", ord, 3'b010);

    // single requester, n = k+1, m = 1
    new_operands(0, 1'b1); ops_left[0] = 1; mv_pulses = 0;
    run_ops(2000, "single");
    check_val("single_grant_cycles", grant_cyc[0], NB);
    check_val("single_mult_valid", mv_pulses, NB);

    // bubbled feed
    alt_feed = 1; new_operands(0, 1'b0); ops_left[0] = 1;
    run_ops(3000, "bubble");
    check_val("bubble_grant_cycles", grant_cyc[0], 2*NB);
    alt_feed = 0;

    // non-owner noise and spurious multiplier strobes while not draining
    noise1 = 1; mult_noise = 1; beef_seen = 0;
    new_operands(0, 1'b0); ops_left[0] = 1;
    run_ops(2000, "noise");
    check_val("noise_beef_seen", beef_seen, 0);
    noise1 = 0; mult_noise = 0;

    // ready stall for requester 1
    force_unready = 1; new_operands(1, 1'b0); ops_left[1] = 1;
    for (int k = 0; k < 8; k++) begin
      cycle();
      check_val("stall_grant", grant_out, 2'b00);
    end
    force_unready = 0;
    cycle();
    check_val("stall_grant_pre", grant_out, 2'b00);
    cycle();
    check_val("stall_grant_rise", grant_out, 2'b10);
    run_ops(2000, "stall");

    // reset in the middle of a feed, then a clean operation
    new_operands(0, 1'b0); ops_left[0] = 1;
    c = 0;
    while (!(active[0] && sent[0] == 60) && c < 500) begin cycle(); c++; end
    check_val("reach_blk60", (active[0] && sent[0] == 60), 1);
    rst_req = 1'b1;
    cycle();
    rst_req = 1'b0;
    cycle();
    check_val("post_reset_busy", busy_out, 0);
    new_operands(0, 1'b0); ops_left[0] = 1;
    run_ops(2000, "after_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
